tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_pkg.sv | 34 +++
 rtl/tmds_symbol_decode.sv | 60 ++++++
 rtl/tmds_decoder.sv | 171 +++++++++++++++++
 tb/tb_tmds_decoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// ============================================================
// Package : tmds_pkg -- TMDS token constants, TERC4 table, FSM states
// Revision: 1.0
// ============================================================
`default_nettype none

package tmds_pkg;

    localparam logic [9:0] C_CTRL_00 = 10'h354;
    localparam logic [9:0] C_CTRL_01 = 10'h0AB;
    localparam logic [9:0] C_CTRL_10 = 10'h154;
    localparam logic [9:0] C_CTRL_11 = 10'h2AB;

    localparam logic [9:0] C_GUARD_A = 10'h2CC;
    localparam logic [9:0] C_GUARD_B = 10'h133;

    // Index is the 4-bit TERC4 value, entry is the 10-bit word (bit 0 sent first).
    localparam logic [9:0] C_TERC4_TABLE [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2,
        10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6,
        10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
// ============================================================
// Module : tmds_symbol_decode -- combinational decode of one TMDS word
// Revision: 1.0
// ============================================================
`default_nettype none

module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_sym,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_is_ctrl,
    output logic [3:0] o_terc4,
    output logic       o_is_terc4,
    output logic       o_is_guard
);

    logic [7:0] w_q;
    logic [7:0] w_data;

    always_comb begin
        w_q       = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
        w_data    = 8'h00;
        w_data[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            w_data[i] = i_sym[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    assign o_data = w_data;

    always_comb begin
        o_ctrl    = 2'b00;
        o_is_ctrl = 1'b0;
        case (i_sym)
            C_CTRL_00: begin o_ctrl = 2'b00; o_is_ctrl = 1'b1; end
            C_CTRL_01: begin o_ctrl = 2'b01; o_is_ctrl = 1'b1; end
            C_CTRL_10: begin o_ctrl = 2'b10; o_is_ctrl = 1'b1; end
            C_CTRL_11: begin o_ctrl = 2'b11; o_is_ctrl = 1'b1; end
            default:   begin o_ctrl = 2'b00; o_is_ctrl = 1'b0; end
        endcase
    end

    always_comb begin
        o_terc4    = 4'h0;
        o_is_terc4 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (i_sym == C_TERC4_TABLE[k]) begin
                o_terc4    = 4'(k);
                o_is_terc4 = 1'b1;
            end
        end
    end

    assign o_is_guard = (i_sym == C_GUARD_A) || (i_sym == C_GUARD_B);

endmodule

`default_nettype wire

// File: rtl/tmds_decoder.sv
// ============================================================
// Module : tmds_decoder -- TMDS word aligner (bitslip search) and decoder
// Revision: 1.0
// ============================================================
`default_nettype none

module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_LOCK_RUN = 8,
    parameter int SEARCH_WINDOW = 1024,
    parameter int SLIP_SETTLE   = 4,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] tmds_in,
    output logic       bitslip,
    output logic       aligned,
    output logic       valid,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       is_ctrl,
    output logic [3:0] terc4,
    output logic       is_terc4,
    output logic       is_guard
);

    localparam int RUN_W  = $clog2(CTRL_LOCK_RUN + 1);
    localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
    localparam int SET_W  = $clog2(SLIP_SETTLE + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    logic [9:0]  tmds_q;
    state_t      state_q,   state_d;
    logic [RUN_W-1:0]  run_q,    run_d;
    logic [WIN_W-1:0]  win_q,    win_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [LOSS_W-1:0] loss_q,   loss_d;
    logic        bitslip_q, bitslip_d;
    logic        aligned_q, aligned_d;
    logic        valid_q;
    logic [7:0]  data_q;
    logic [1:0]  ctrl_q;
    logic        is_ctrl_q;
    logic [3:0]  terc4_q;
    logic        is_terc4_q;
    logic        is_guard_q;

    logic [7:0]  w_data;
    logic [1:0]  w_ctrl;
    logic        w_is_ctrl;
    logic [3:0]  w_terc4;
    logic        w_is_terc4;
    logic        w_is_guard;

    tmds_symbol_decode u_sym_dec (
        .i_sym      (tmds_q),
        .o_data     (w_data),
        .o_ctrl     (w_ctrl),
        .o_is_ctrl  (w_is_ctrl),
        .o_terc4    (w_terc4),
        .o_is_terc4 (w_is_terc4),
        .o_is_guard (w_is_guard)
    );

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        win_d    = win_q;
        settle_d = settle_q;
        loss_d   = loss_q;
        case (state_q)
            ST_SEARCH: begin
                run_d = w_is_ctrl ? run_q + RUN_W'(1) : '0;
                win_d = win_q + WIN_W'(1);
                // A lock on the last window word wins over slipping.
                if (w_is_ctrl && (run_q == RUN_W'(CTRL_LOCK_RUN - 1))) begin
                    state_d = ST_LOCKED;
                    run_d   = '0;
                    win_d   = '0;
                    loss_d  = '0;
                end else if (win_q == WIN_W'(SEARCH_WINDOW - 1)) begin
                    state_d = ST_SLIP;
                    run_d   = '0;
                    win_d   = '0;
                end
            end
            ST_SLIP: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                run_d = '0;
                win_d = '0;
                if (settle_q == SET_W'(SLIP_SETTLE - 1)) begin
                    state_d  = ST_SEARCH;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_LOCKED: begin
                if (w_is_ctrl) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_W'(LOSS_TIMEOUT - 1)) begin
                    state_d = ST_SEARCH;
                    loss_d  = '0;
                    run_d   = '0;
                    win_d   = '0;
                end else begin
                    loss_d = loss_q + LOSS_W'(1);
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
        bitslip_d = (state_d == ST_SLIP);
        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmds_q     <= '0;
            state_q    <= ST_SEARCH;
            run_q      <= '0;
            win_q      <= '0;
            settle_q   <= '0;
            loss_q     <= '0;
            bitslip_q  <= 1'b0;
            aligned_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ctrl_q     <= '0;
            is_ctrl_q  <= 1'b0;
            terc4_q    <= '0;
            is_terc4_q <= 1'b0;
            is_guard_q <= 1'b0;
        end else begin
            tmds_q     <= tmds_in;
            state_q    <= state_d;
            run_q      <= run_d;
            win_q      <= win_d;
            settle_q   <= settle_d;
            loss_q     <= loss_d;
            bitslip_q  <= bitslip_d;
            aligned_q  <= aligned_d;
            valid_q    <= aligned_q;
            data_q     <= w_data;
            ctrl_q     <= w_ctrl;
            is_ctrl_q  <= w_is_ctrl;
            terc4_q    <= w_terc4;
            is_terc4_q <= w_is_terc4;
            is_guard_q <= w_is_guard;
        end
    end

    assign bitslip  = bitslip_q;
    assign aligned  = aligned_q;
    assign valid    = valid_q;
    assign data     = data_q;
    assign ctrl     = ctrl_q;
    assign is_ctrl  = is_ctrl_q;
    assign terc4    = terc4_q;
    assign is_terc4 = is_terc4_q;
    assign is_guard = is_guard_q;

endmodule

`default_nettype wire

// File: tb/tb_tmds_decoder.sv
// ============================================================
// Module : tb_tmds_decoder -- directed self-checking bench for tmds_decoder
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_tmds_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] tmds_in = 10'h000;
    logic       bitslip, aligned, valid, is_ctrl, is_terc4, is_guard;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [3:0] terc4;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] terc4_ref [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };
    logic [9:0] ctrl_ref [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    tmds_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tmds_in  (tmds_in),
        .bitslip  (bitslip),
        .aligned  (aligned),
        .valid    (valid),
        .data     (data),
        .ctrl     (ctrl),
        .is_ctrl  (is_ctrl),
        .terc4    (terc4),
        .is_terc4 (is_terc4),
        .is_guard (is_guard)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a word for two clocks so the outputs show its decode.
    task automatic apply(input logic [9:0] w);
        tmds_in = w;
        step();
        step();
    endtask

    function automatic logic [9:0] rot(input logic [9:0] w, input int o);
        logic [19:0] d;
        d = {w, w} >> (o % 10);
        return d[9:0];
    endfunction

    // Reference DVI 8b/10b encoder for a given running disparity.
    function automatic logic [9:0] tmds_enc(input logic [7:0] d, input int cnt);
        logic [8:0] qm;
        int n1d, n1q, n0q;
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += int'(d[i]);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = 0;
        for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
        n0q = 8 - n1q;
        if (cnt == 0 || n1q == n0q)
            return {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
        else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q))
            return {1'b1, qm[8], ~qm[7:0]};
        else
            return {1'b0, qm[8], qm[7:0]};
    endfunction

    initial begin
        int slips;
        int quiet;
        int offs;
        int found;
        int cnts [3];
        cnts = '{0, 4, -4};

        repeat (3) step();
        chk("rst_bitslip", bitslip, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_is_ctrl", is_ctrl, 0);
        chk("rst_terc4", terc4, 0);
        chk("rst_is_terc4", is_terc4, 0);
        chk("rst_is_guard", is_guard, 0);

        // Continuous 0x354 after reset: lock on the 8th token.
        tmds_in = 10'h354;
        @(negedge clk) rst_n = 1'b1;
        slips = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bitslip) slips++;
            if (i == 8)  chk("lock_not_yet", aligned, 0);
            if (i == 9)  begin chk("lock_aligned", aligned, 1); chk("lock_valid_lag", valid, 0); end
            if (i == 10) begin
                chk("lock_valid", valid, 1);
                chk("lock_ctrl", ctrl, 2'b00);
                chk("lock_is_ctrl", is_ctrl, 1);
            end
        end
        chk("lock_no_slip", slips, 0);

        apply(10'h1F0);
        chk("vid_1f0_data", data, 8'h10);
        chk("vid_1f0_valid", valid, 1);
        chk("vid_1f0_is_ctrl", is_ctrl, 0);
        chk("vid_1f0_is_guard", is_guard, 0);

        for (int v = 0; v < 256; v++) begin
            for (int c = 0; c < 3; c++) begin
                apply(tmds_enc(8'(v), cnts[c]));
                chk($sformatf("vid_rt_%0d_%0d", v, cnts[c]), data, v);
            end
        end
        chk("vid_rt_valid", valid, 1);

        for (int k = 0; k < 16; k++) begin
            apply(terc4_ref[k]);
            chk($sformatf("terc4_%0d", k), terc4, k);
            chk($sformatf("terc4_hit_%0d", k), is_terc4, 1);
            chk($sformatf("terc4_notctrl_%0d", k), is_ctrl, 0);
        end
        apply(10'h2CC);
        chk("guard_2cc", is_guard, 1);
        chk("guard_2cc_terc4", terc4, 8);
        chk("guard_2cc_hit", is_terc4, 1);
        apply(10'h133);
        chk("guard_133", is_guard, 1);
        chk("guard_133_hit", is_terc4, 0);
        for (int k = 0; k < 4; k++) begin
            apply(ctrl_ref[k]);
            chk($sformatf("ctrl_val_%0d", k), ctrl, k);
            chk($sformatf("ctrl_is_%0d", k), is_ctrl, 1);
            chk($sformatf("ctrl_noterc4_%0d", k), is_terc4, 0);
        end

        // Loss of lock after 4096 words without a control token.
        tmds_in = 10'h354;
        repeat (3) step();
        tmds_in = 10'h1F0;
        repeat (4096) step();
        chk("loss_hold_4096", aligned, 1);
        step();
        chk("loss_drop", aligned, 0);
        step();
        chk("loss_valid_drop", valid, 0);

        tmds_in = 10'h354;
        repeat (12) step();
        chk("relock", aligned, 1);
        tmds_in = 10'h1F0;
        repeat (4095) step();
        tmds_in = 10'h354;
        step();
        tmds_in = 10'h1F0;
        step();
        chk("loss_rescued", aligned, 1);
        repeat (3) step();
        chk("loss_rescued_later", aligned, 1);
        chk("pre_rst_data", data, 8'h10);

        // Asynchronous reset while locked.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_lock_aligned", aligned, 0);
        chk("rst_lock_valid", valid, 0);
        chk("rst_lock_data", data, 0);

        // Rotated 0x0AB stream through a bitslip-honouring deserializer model.
        offs = 7;
        tmds_in = rot(10'h0AB, offs);
        @(negedge clk) rst_n = 1'b1;
        slips = 0;
        quiet = 100;
        for (int i = 0; i < 5000 && !aligned; i++) begin
            step();
            if (bitslip) begin
                chk($sformatf("slip_gap_%0d", slips), (quiet >= 4), 1);
                slips++;
                offs++;
                quiet = 0;
            end else begin
                quiet++;
            end
            tmds_in = rot(10'h0AB, offs);
        end
        chk("slip_count", slips, 3);
        chk("slip_aligned", aligned, 1);
        chk("slip_last_gap", (quiet >= 4), 1);
        step();
        step();
        chk("slip_ctrl", ctrl, 2'b01);
        chk("slip_is_ctrl", is_ctrl, 1);
        chk("slip_valid", valid, 1);

        // Reset asserted during the SLIP cycle.
        rst_n = 1'b0;
        tmds_in = 10'h1F0;
        repeat (2) step();
        @(negedge clk) rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 1200 && found == 0; i++) begin
            step();
            if (bitslip) found = 1;
        end
        chk("slip_reached", found, 1);
        chk("slip_data_before_rst", data, 8'h10);
        rst_n = 1'b0;
        #1;
        chk("rst_slip_bitslip", bitslip, 0);
        chk("rst_slip_aligned", aligned, 0);
        chk("rst_slip_valid", valid, 0);
        chk("rst_slip_data", data, 0);
        chk("rst_slip_is_guard", is_guard, 0);
        tmds_in = 10'h354;
        @(negedge clk) rst_n = 1'b1;
        slips = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (bitslip) slips++;
            if (i == 8) chk("restart_not_yet", aligned, 0);
            if (i == 9) chk("restart_aligned", aligned, 1);
        end
        chk("restart_no_slip", slips, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
